axi_mem_arbiter: RTL and testbench
==================================

# axi_mem_arbiter

Two-port arbiter that shares the single AXI full master (simple `ren`/`wen`/`addr` side) between the instruction-fetch unit (read-only) and the load/store unit (read/write). It latches one request at a time, issues it to the master as a one-cycle command pulse, waits for completion, and returns the data or error to the winning requester. It has a completion watchdog and selectable arbitration policy. It sits between the pipeline's IF/MEM stages and the AXI master.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width for requester and master sides.
- `TIMEOUT_CYCLES`, 255, maximum WAIT cycles before an error response. Range 1..65535.
- `M_AXI_ACLK` in 1: the only clock. All logic is on the rising edge.
- `M_AXI_ARESETN` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held high until `if_rvalid`.
- `if_addr` in ADDR_W: fetch address. Stable while `if_req` is high.
- `if_rvalid` out 1: one-cycle fetch response pulse.
- `if_rdata` out DATA_W: fetch data. Valid while `if_rvalid` is high.
- `if_stall` out 1: high when `if_req` is high and `if_rvalid` is low.
- `ls_req` in 1: LSU request. Held high until `ls_rvalid`.
- `ls_we` in 1: 1 = write, 0 = read.
- `ls_addr` in ADDR_W: LSU address.
- `ls_wdata` in DATA_W: LSU write data.
- `ls_wstrb` in DATA_W/8: LSU byte strobes.
- `ls_rvalid` out 1: one-cycle LSU completion pulse. Pulses for reads and for writes.
- `ls_rdata` out DATA_W: LSU read data. Reads 0 for writes.
- `ls_stall` out 1: high when `ls_req` is high and `ls_rvalid` is low.
- `bus_err` out 1: qualifies the current `*_rvalid` pulse as a timeout.
- `m_ren` / `m_wen` out 1: one-cycle command pulse to the master.
- `m_addr` out ADDR_W: registered address, held from ISSUE until the return to IDLE.
- `m_wdata` out DATA_W: registered write data, held like `m_addr`.
- `m_wstrb` out DATA_W/8: registered strobes, held like `m_addr`.
- `m_done` in 1: master completion pulse. Indicates last R beat accepted, or write END reached.
- `m_rdata` in DATA_W: read data, sampled when `m_done` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- **IDLE**
  - If any request is high, select a winner and latch its addr, wdata, wstrb, we and the source ID. Go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE**
  - Drive `m_ren` (read) or `m_wen` (write) high for exactly this one cycle.
  - Clear the watchdog. Go to WAIT.
- **WAIT**
  - On `m_done`: capture `m_rdata` (read) or 0 (write). Go to RESP.
  - Otherwise, when the watchdog reaches `TIMEOUT_CYCLES`: set `bus_err`, force data to 0, go to RESP, and mark DRAIN pending.
- **RESP**
  - Pulse the owner's `*_rvalid` for one cycle, with `*_rdata` and `bus_err` driven.
  - Go to IDLE, or to DRAIN if DRAIN is pending.
- **DRAIN**
  - Wait for the late `m_done` and discard its data. Then go to IDLE.
  - No new request is accepted while in DRAIN.
- Watchdog: 16-bit counter, incremented each WAIT cycle and saturating. If `m_done` and the timeout occur in the same cycle, `m_done` wins and no error is raised.
- Arbitration is decided only in IDLE. A granted transaction is never pre-empted. A requester that drops `req` after the grant still receives its `rvalid`, and the pulse is ignored.
- `m_done` seen in IDLE, ISSUE or RESP is ignored.
- Reset, at any time including mid-transaction:
  - FSM returns to IDLE and the watchdog clears.
  - All outputs go to 0: `m_ren`, `m_wen`, `m_addr`, `m_wdata`, `m_wstrb`, both `rvalid`, both `rdata`, `bus_err`.
  - `*_stall` stays combinational: equal to `req` while the corresponding `rvalid` is 0.
  - No response is produced for an aborted transaction.

## Timing
- Request sampled at edge 0 → `m_ren`/`m_wen` high during cycle 1 → WAIT from cycle 2.
- `m_done` at cycle k ≥ 2 → `*_rvalid` in cycle k+1.
- Minimum request-to-response time is 3 cycles, plus master latency.
- Back-to-back: the next IDLE decision is in cycle k+2. The earliest next ISSUE is cycle k+3.
- Timeout: `rvalid` and `bus_err` appear `TIMEOUT_CYCLES`+1 cycles after entering WAIT.

## Configuration
- `AXI_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_owner` register is updated at each grant.
  - On a simultaneous request, the port that did not win last is granted.
  - `last_owner` resets to IF, so the first tie goes to LSU.
- `AXI_ARB_RR_EN` undefined: fixed priority. LSU always wins a tie.

## Test plan
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x8000_0000; master gives `m_done` 4 cycles after `m_ren` with `m_rdata`=0x0000_0013.
  - Required: `m_ren` is a single-cycle pulse; `if_rvalid` is a single-cycle pulse with `if_rdata`=0x13; `bus_err`=0.
- LSU write:
  - Stimulus: `ls_we`=1, `ls_addr`=0x1000, `ls_wdata`=0xDEAD_BEEF, `ls_wstrb`=0xF.
  - Required: `m_wen` pulse with `m_addr`/`m_wdata`/`m_wstrb` matching the stimulus and held through WAIT; `ls_rvalid` with `ls_rdata`=0.
- Simultaneous requests for 4 back-to-back transactions:
  - Fixed priority: grants LS, LS, LS, LS while `ls_req` stays asserted.
  - With `AXI_ARB_RR_EN`: grants LS, IF, LS, IF.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=8, no `m_done`.
  - Required: `ls_rvalid` and `bus_err` 9 cycles after WAIT entry, `ls_rdata`=0.
  - Then a late `m_done` returns the FSM to IDLE; a pending `if_req` is held off until that point.
- Reset in WAIT:
  - Stimulus: assert `M_AXI_ARESETN` asynchronously mid-transaction.
  - Required: all outputs 0 within the same cycle, no `rvalid` pulse, and the next request is served normally.
- Same-cycle `m_done` and timeout:
  - Stimulus: `m_done`=1 with `m_rdata`=0x55 in the timeout cycle.
  - Required: `if_rdata`=0x55, `bus_err`=0, no DRAIN.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Purpose: shares one simple-command AXI master between the fetch unit (read-only) and the load/store unit.
// Latency: request seen in IDLE -> command pulse next cycle -> *_rvalid one cycle after m_done (min 3 cycles + master).
// Backpressure: one transaction in flight; losing/waiting requesters see *_stall until their rvalid pulse.
// Build option: define AXI_ARB_RR_EN for round-robin arbitration; otherwise the LSU wins every tie.
module axi_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_stall,
    output logic                bus_err,
    output logic                m_ren,
    output logic                m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_done,
    input  logic [DATA_W-1:0]   m_rdata
);
    localparam int          STRB_W      = DATA_W / 8;
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
    localparam logic        OWN_IF      = 1'b0;
    localparam logic        OWN_LS      = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                we_q, we_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                drain_q, drain_d;
    logic [15:0]         wdog_q, wdog_d;
    logic                grant_ls;

`ifdef AXI_ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // Round-robin: on a tie, the port that did not win the previous grant goes first.
    always_comb begin
        grant_ls     = ls_req && (!if_req || (last_owner_q == OWN_IF));
        last_owner_d = last_owner_q;
        if ((state_q == S_IDLE) && (if_req || ls_req)) begin
            last_owner_d = grant_ls ? OWN_LS : OWN_IF;
        end
    end

    // Last-winner register; starts at IF so the first tie goes to the LSU.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // Fixed priority: any LSU request beats a fetch.
    always_comb begin
        grant_ls = ls_req;
    end
`endif

    // Next-state logic: grant in IDLE only, one command pulse, wait with watchdog, respond, optionally drain.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        owner_d = owner_q;
        data_d  = data_q;
        err_d   = err_q;
        drain_d = drain_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    if (grant_ls) begin
                        owner_d = OWN_LS;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        wstrb_d = ls_wstrb;
                        we_d    = ls_we;
                    end else begin
                        owner_d = OWN_IF;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                        we_d    = 1'b0;
                    end
                    data_d  = '0;
                    err_d   = 1'b0;
                    drain_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving in the timeout cycle still counts as a normal completion.
                if (m_done) begin
                    data_d  = we_q ? '0 : m_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q >= TIMEOUT_VAL) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = S_RESP;
                end else if (wdog_q != 16'hFFFF) begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = drain_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                // The master still owes a completion for the timed-out command; swallow it.
                if (m_done) begin
                    drain_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset aborts any transaction silently.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            owner_q <= OWN_IF;
            data_q  <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            err_q   <= err_d;
            drain_q <= drain_d;
            wdog_q  <= wdog_d;
        end
    end

    assign m_ren     = (state_q == S_ISSUE) && !we_q;
    assign m_wen     = (state_q == S_ISSUE) && we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign ls_rvalid = (state_q == S_RESP) && (owner_q == OWN_LS);
    assign if_rdata  = if_rvalid ? data_q : '0;
    assign ls_rdata  = ls_rvalid ? data_q : '0;
    assign bus_err   = (state_q == S_RESP) && err_q;
    assign if_stall  = if_req && !if_rvalid;
    assign ls_stall  = ls_req && !ls_rvalid;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Purpose: self-checking bench for axi_mem_arbiter with a latency-programmable master model.
// Latency: checks issue, response, timeout and drain-release timing in cycles.
// Backpressure: requesters hold req until their rvalid; stall is checked while waiting.
module tb_axi_mem_arbiter;
    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_stall;
    logic        bus_err;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_done;
    logic [31:0] m_rdata;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_stall(ls_stall), .bus_err(bus_err),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_done(m_done), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        is_ls;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        cmd_prev = 1'b0;
    logic        mst_enable = 1'b0;
    int          mst_lat = 1;
    logic [31:0] mst_rdata = '0;
    int          kick_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: m_done mst_lat cycles after a command, or one cycle after a kick (junk data).
    initial begin
        int cnt;
        int seen;
        logic [31:0] dat;
        cnt = 0; seen = 0; dat = '0;
        m_done = 1'b0; m_rdata = 32'hFFFF_FFFF;
        forever begin
            @(negedge clk);
            if ((m_ren || m_wen) && mst_enable) begin
                cnt = mst_lat;
                dat = mst_rdata;
            end
            if (kick_cnt != seen) begin
                seen = kick_cnt;
                cnt  = 1;
                dat  = 32'hEEEE_EEEE;
            end
            @(posedge clk); #1;
            if (cnt == 1) begin
                m_done = 1'b1; m_rdata = dat;
            end else begin
                m_done = 1'b0; m_rdata = 32'hFFFF_FFFF;
            end
            if (cnt > 0) cnt--;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expected event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // Advance to the next falling edge and run the response scoreboard and pulse-width monitor.
    task automatic tick();
        exp_t e;
        logic [31:0] rd;
        @(negedge clk);
        if (m_ren || m_wen) chk("cmd_pulse_width", 32'(cmd_prev), 32'd0);
        cmd_prev = m_ren | m_wen;
        if (if_rvalid && ls_rvalid) begin
            fail_now("dual_rvalid");
        end else if (if_rvalid || ls_rvalid) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_rvalid");
            end else begin
                e  = sb.pop_front();
                rd = if_rvalid ? if_rdata : ls_rdata;
                chk("rsp_port_is_ls", 32'(ls_rvalid), 32'(e.is_ls));
                chk("rsp_rdata", rd, e.rdata);
                chk("rsp_bus_err", 32'(bus_err), 32'(e.err));
            end
        end
    endtask

    task automatic drive_pt();
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input logic is_ls, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_ls = is_ls; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_cmd(input int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (m_ren || m_wen) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) fail_now("wait_cmd");
    endtask

    task automatic wait_rv(input logic is_ls, input int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (is_ls ? ls_rvalid : if_rvalid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) fail_now("wait_rvalid");
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   c_req, c_cmd, c_rv;
        logic hold_ok;
        tick();
        drive_pt();
        mst_enable = 1'b1; mst_lat = v.lat; mst_rdata = v.mrdata;
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_wstrb = v.wstrb;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        c_req = cyc;
        push_exp(v.is_ls, v.exp_rdata, v.exp_err);
        wait_cmd(8, c_cmd);
        chk({tag, ":issue_latency"}, 32'(c_cmd - c_req), 32'd1);
        chk({tag, ":cmd_kind"}, 32'({m_wen, m_ren}), v.we ? 32'd2 : 32'd1);
        chk({tag, ":m_addr"}, m_addr, v.addr);
        if (v.we) begin
            chk({tag, ":m_wdata"}, m_wdata, v.wdata);
            chk({tag, ":m_wstrb"}, 32'(m_wstrb), 32'(v.wstrb));
        end
        hold_ok = 1'b1;
        c_rv = -1;
        for (int i = 0; i < v.lat + 6; i++) begin
            tick();
            if (v.is_ls ? ls_rvalid : if_rvalid) begin
                c_rv = cyc;
                chk({tag, ":stall_at_rvalid"}, 32'(v.is_ls ? ls_stall : if_stall), 32'd0);
                break;
            end
            if (m_addr !== v.addr) hold_ok = 1'b0;
            if (v.we && ((m_wdata !== v.wdata) || (m_wstrb !== v.wstrb))) hold_ok = 1'b0;
            if ((v.is_ls ? ls_stall : if_stall) !== 1'b1) hold_ok = 1'b0;
        end
        if (c_rv < 0) fail_now({tag, ":resp_timeout"});
        else chk({tag, ":resp_latency"}, 32'(c_rv - c_cmd), 32'(v.lat + 1));
        chk({tag, ":hold_and_stall_in_wait"}, 32'(hold_ok), 32'd1);
        drive_pt();
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        bit   tie_exp[4];
        int   c0, c1, cd, ci, seen;
        logic saw_cmd, stall_ok;

        // Single fetch, LSU write, LSU read, strobed write, m_done on the timeout cycle, follow-up fetch.
        vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 4, 32'h0000_0013, 32'h0000_0013, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3, 32'h7777_7777, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         4'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_3000, 32'h0000_00AB, 4'h1, 8, 32'h3333_3333, 32'h0,         1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 9, 32'h0000_0055, 32'h0000_0055, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0,         4'h0, 2, 32'h1234_5678, 32'h1234_5678, 1'b0};
`ifdef AXI_ARB_RR_EN
        tie_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        tie_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        #1 rst = 1'b1;

        // Reset state, and stall passing req through while in reset.
        tick(); tick();
        chk("rst:m_ren", 32'(m_ren), 0);
        chk("rst:m_wen", 32'(m_wen), 0);
        chk("rst:m_addr", m_addr, 0);
        chk("rst:m_wdata", m_wdata, 0);
        chk("rst:m_wstrb", 32'(m_wstrb), 0);
        chk("rst:if_rvalid", 32'(if_rvalid), 0);
        chk("rst:ls_rvalid", 32'(ls_rvalid), 0);
        chk("rst:bus_err", 32'(bus_err), 0);
        chk("rst:if_stall_idle", 32'(if_stall), 0);
        drive_pt();
        if_req = 1'b1; ls_req = 1'b1;
        tick();
        chk("rst:if_stall_req", 32'(if_stall), 1);
        chk("rst:ls_stall_req", 32'(ls_stall), 1);
        chk("rst:no_issue", 32'(m_ren | m_wen), 0);
        drive_pt();
        if_req = 1'b0; ls_req = 1'b0; rst = 1'b0;

        // Four back-to-back tied transactions with both requests held.
        tick();
        drive_pt();
        mst_enable = 1'b1; mst_lat = 2; mst_rdata = 32'h0000_00A5;
        if_req = 1'b1; if_addr = 32'h8000_0100;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_4000;
        for (int k = 0; k < 4; k++) push_exp(tie_exp[k], 32'h0000_00A5, 1'b0);
        seen = 0;
        for (int i = 0; i < 80 && seen < 4; i++) begin
            tick();
            if (if_rvalid || ls_rvalid) seen++;
        end
        drive_pt();
        if_req = 1'b0; ls_req = 1'b0;
        chk("tie:count", 32'(seen), 32'd4);

        // Timeout, then a fetch held off until the late completion drains.
        tick();
        drive_pt();
        mst_enable = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_5000;
        push_exp(1'b1, 32'h0, 1'b1);
        wait_cmd(8, c0);
        wait_rv(1'b1, TO + 12, c1);
        if (c1 >= 0) chk("to:latency_from_cmd", 32'(c1 - c0), 32'(TO + 2));
        drive_pt();
        ls_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h8000_0200;
        mst_enable = 1'b1; mst_lat = 3; mst_rdata = 32'h600D_F00D;
        push_exp(1'b0, 32'h600D_F00D, 1'b0);
        saw_cmd = 1'b0; stall_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_ren || m_wen) saw_cmd = 1'b1;
            if (if_stall !== 1'b1) stall_ok = 1'b0;
        end
        chk("to:drain_blocks_issue", 32'(saw_cmd), 0);
        chk("to:drain_if_stall", 32'(stall_ok), 1);
        drive_pt();
        kick_cnt++;
        cd = -1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_done) begin
                cd = cyc;
                break;
            end
        end
        wait_cmd(6, ci);
        chk("to:drain_release", 32'(ci - cd), 32'd2);
        wait_rv(1'b0, 10, c1);
        drive_pt();
        if_req = 1'b0;

        // Asynchronous reset in WAIT: outputs clear at once, no response ever appears.
        tick();
        drive_pt();
        mst_enable = 1'b1; mst_lat = 6; mst_rdata = 32'h1111_1111;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_6000; ls_wdata = 32'h1234_ABCD; ls_wstrb = 4'hC;
        wait_cmd(8, c0);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst:m_ren", 32'(m_ren), 0);
        chk("arst:m_wen", 32'(m_wen), 0);
        chk("arst:m_addr", m_addr, 0);
        chk("arst:m_wdata", m_wdata, 0);
        chk("arst:m_wstrb", 32'(m_wstrb), 0);
        chk("arst:ls_rvalid", 32'(ls_rvalid), 0);
        chk("arst:ls_rdata", ls_rdata, 0);
        chk("arst:if_rdata", if_rdata, 0);
        chk("arst:bus_err", 32'(bus_err), 0);
        chk("arst:ls_stall", 32'(ls_stall), 1);
        drive_pt();
        ls_req = 1'b0;
        tick();
        drive_pt();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) tick();
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
